// File: rtl/vga_tim_ctrl.sv
// vga_tim_ctrl: video timing sequencer with shadow/active timing sets, frame-end commit.
// Define VGA_TIM_CTRL_VINT_EN to add the vint pulse and the frame_cnt counter.
module vga_tim_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_en,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdat,
    input  logic        cfg_commit,
    input  logic        h_done,
    input  logic        v_done,
    output logic        tg_rst,
    output logic        h_ena,
    output logic        v_ena,
    output logic [7:0]  h_tsync,
    output logic [7:0]  h_tgdel,
    output logic [15:0] h_tgate,
    output logic [15:0] h_tlen,
    output logic [7:0]  v_tsync,
    output logic [7:0]  v_tgdel,
    output logic [15:0] v_tgate,
    output logic [15:0] v_tlen,
    output logic        busy,
    output logic        pending,
    output logic        cfg_err
`ifdef VGA_TIM_CTRL_VINT_EN
    ,
    output logic        vint,
    output logic [15:0] frame_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;
    state_t state, state_nxt;
    logic [31:0] sh_h, sh_v;
    logic [15:0] sh_hlen, sh_vlen;
    logic act, fe, len_ok, apply;
    logic tg_rst_d, h_ena_d, v_ena_d, busy_d;

    assign act    = state == RUN || state == STOP;
    assign fe     = act & v_ena & v_done;
    assign len_ok = sh_hlen != 16'd0 && sh_vlen != 16'd0;
    assign apply  = state == LOAD || (fe && pending);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_en && len_ok) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (!ctrl_en) state_nxt = STOP;
            STOP:    if (fe) state_nxt = IDLE; else if (ctrl_en) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tg_rst_d = !act;
        h_ena_d  = act;
        v_ena_d  = act & h_done;
        busy_d   = act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tg_rst  <= 1'b1;
            h_ena   <= 1'b0;
            v_ena   <= 1'b0;
            busy    <= 1'b0;
            pending <= 1'b0;
            cfg_err <= 1'b0;
            sh_h    <= '0;
            sh_v    <= '0;
            sh_hlen <= '0;
            sh_vlen <= '0;
            {h_tsync, h_tgdel, h_tgate, h_tlen} <= '0;
            {v_tsync, v_tgdel, v_tgate, v_tlen} <= '0;
        end else begin
            state   <= state_nxt;
            tg_rst  <= tg_rst_d;
            h_ena   <= h_ena_d;
            v_ena   <= v_ena_d;
            busy    <= busy_d;
            if (cfg_we && cfg_addr == 2'd0) sh_h <= cfg_wdat;
            if (cfg_we && cfg_addr == 2'd1) sh_hlen <= cfg_wdat[15:0];
            if (cfg_we && cfg_addr == 2'd2) sh_v <= cfg_wdat;
            if (cfg_we && cfg_addr == 2'd3) sh_vlen <= cfg_wdat[15:0];
            if (apply) begin
                {h_tsync, h_tgdel, h_tgate} <= sh_h;
                {v_tsync, v_tgdel, v_tgate} <= sh_v;
                h_tlen <= sh_hlen;
                v_tlen <= sh_vlen;
            end
            // a commit landing on the applying frame end stays pending for the next one
            pending <= state == LOAD ? 1'b0 : (fe && pending) ? cfg_commit : pending | cfg_commit;
            cfg_err <= (state == IDLE && ctrl_en && !len_ok) | (cfg_err & !cfg_we);
        end
    end

`ifdef VGA_TIM_CTRL_VINT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vint      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vint      <= fe;
            frame_cnt <= state == LOAD ? 16'd0 : frame_cnt + {15'd0, fe};
        end
    end
`endif
endmodule
